cpu_phase_gen: RTL and testbench

Generates the MC6809 quadrature bus clocks (E and Q) and the CPU reset sequence from a PLL output clock, gated on PLL lock. Sits directly downstream of the PLL clock wrapper: it consumes one PLL output clock and the PLL lock flag, and feeds the CPU core and bus glue. E and Q are registered levels plus single-cycle edge strobes for logic clocked on CLK, and E-high can be stretched for slow peripherals.

---
 rtl/cpu_phase_gen.sv | 150 +++++++++++++++
 tb/tb_cpu_phase_gen.sv | 211 +++++++++++++++++++++
 2 files changed

// File: rtl/cpu_phase_gen.sv
// Purpose : MC6809 E/Q quadrature clock and CPU reset sequencer, gated on PLL lock.
// Latency : LOCKED edge reaches the phase state 3 CLK later; levels and strobes are registered.
// Backpressure: STRETCH freezes the last E-high quarter slot for as long as it is held.
//
// Ports:
//   CLK, RESET_N          PLL output clock; asynchronous active-low reset
//   LOCKED                PLL lock flag (asynchronous, double-flop synchronized)
//   STRETCH               holds E high while asserted in the last E-high slot
//   E, Q                  registered bus clock levels (Q leads E by a quarter)
//   E_RISE..Q_FALL        one-CLK strobes, high in the first cycle a new level shows
//   CPU_RESET_N, READY    CPU reset release and "phases running, CPU out of reset"
module cpu_phase_gen #(
    parameter int DIV      = 4,
    parameter int RST_HOLD = 16
) (
    input  logic CLK,
    input  logic RESET_N,
    input  logic LOCKED,
    input  logic STRETCH,
    output logic E,
    output logic Q,
    output logic E_RISE,
    output logic E_FALL,
    output logic Q_RISE,
    output logic Q_FALL,
    output logic CPU_RESET_N,
    output logic READY
);

    localparam int QW = (DIV > 1) ? $clog2(DIV) : 1;
    localparam logic [QW-1:0] QLAST    = QW'(DIV - 1);
    localparam logic [16:0]   HOLD_END = 17'(RST_HOLD);

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_HOLD = 2'd1,
        ST_RUN  = 2'd2
    } state_t;

    logic          lock_meta;
    logic          lock_sync;
    state_t        state, state_n;
    logic [QW-1:0] qcnt, qcnt_n;
    logic [1:0]    ph, ph_n;
    logic [15:0]   hold_cnt, hold_n;
    logic          e_n, q_n;
    logic          e_rise_n, e_fall_n, q_rise_n, q_fall_n;
    logic          cpu_reset_n_n, ready_n;

    always_comb begin
        state_n       = state;
        qcnt_n        = qcnt;
        ph_n          = ph;
        hold_n        = hold_cnt;
        e_n           = 1'b0;
        q_n           = 1'b0;
        e_rise_n      = 1'b0;
        e_fall_n      = 1'b0;
        q_rise_n      = 1'b0;
        q_fall_n      = 1'b0;
        cpu_reset_n_n = 1'b0;
        ready_n       = 1'b0;

        case (state)
            ST_IDLE: begin
                if (lock_sync) begin
                    state_n = ST_HOLD;
                    qcnt_n  = '0;
                    ph_n    = 2'd0;
                    hold_n  = '0;
                end
            end
            ST_HOLD, ST_RUN: begin
                if (!lock_sync) begin
                    // Lock lost: drop everything silently, the forced drop is not an edge.
                    state_n = ST_IDLE;
                    qcnt_n  = '0;
                    ph_n    = 2'd0;
                end else begin
                    if (qcnt == QLAST) begin
                        // Stretch only freezes the final E-high slot; everything else advances.
                        if (!(ph == 2'd3 && STRETCH)) begin
                            qcnt_n = '0;
                            ph_n   = ph + 2'd1;
                            if (ph == 2'd3 && state == ST_HOLD) begin
                                hold_n = hold_cnt + 16'd1;
                                if (({1'b0, hold_cnt} + 17'd1) == HOLD_END) begin
                                    state_n = ST_RUN;
                                end
                            end
                        end
                    end else begin
                        qcnt_n = qcnt + 1'b1;
                    end

                    // ph 0..3 -> E = 0,0,1,1 and Q = 0,1,1,0
                    e_n      = ph_n[1];
                    q_n      = ph_n[1] ^ ph_n[0];
                    e_rise_n = e_n & ~E;
                    e_fall_n = ~e_n & E;
                    q_rise_n = q_n & ~Q;
                    q_fall_n = ~q_n & Q;

                    cpu_reset_n_n = (state_n == ST_RUN);
                    ready_n       = (state_n == ST_RUN);
                end
            end
            default: begin
                state_n = ST_IDLE;
                qcnt_n  = '0;
                ph_n    = 2'd0;
            end
        endcase
    end

    always_ff @(posedge CLK or negedge RESET_N) begin
        if (!RESET_N) begin
            lock_meta   <= 1'b0;
            lock_sync   <= 1'b0;
            state       <= ST_IDLE;
            qcnt        <= '0;
            ph          <= 2'd0;
            hold_cnt    <= '0;
            E           <= 1'b0;
            Q           <= 1'b0;
            E_RISE      <= 1'b0;
            E_FALL      <= 1'b0;
            Q_RISE      <= 1'b0;
            Q_FALL      <= 1'b0;
            CPU_RESET_N <= 1'b0;
            READY       <= 1'b0;
        end else begin
            lock_meta   <= LOCKED;
            lock_sync   <= lock_meta;
            state       <= state_n;
            qcnt        <= qcnt_n;
            ph          <= ph_n;
            hold_cnt    <= hold_n;
            E           <= e_n;
            Q           <= q_n;
            E_RISE      <= e_rise_n;
            E_FALL      <= e_fall_n;
            Q_RISE      <= q_rise_n;
            Q_FALL      <= q_fall_n;
            CPU_RESET_N <= cpu_reset_n_n;
            READY       <= ready_n;
        end
    end

endmodule

// File: tb/tb_cpu_phase_gen.sv
// Purpose : checks cpu_phase_gen (DIV=4/RST_HOLD=2 and DIV=1/RST_HOLD=1) against a timeline model.
// Latency : outputs compared 1 time unit after every rising CLK edge.
// Backpressure: STRETCH driven directed and at random.
module tb_cpu_phase_gen;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic reset_n, locked, stretch;
    logic e4, q4, er4, ef4, qr4, qf4, cr4, rd4;
    logic e1, q1, er1, ef1, qr1, qf1, cr1, rd1;

    cpu_phase_gen #(.DIV(4), .RST_HOLD(2)) dut4 (
        .CLK(clk), .RESET_N(reset_n), .LOCKED(locked), .STRETCH(stretch),
        .E(e4), .Q(q4), .E_RISE(er4), .E_FALL(ef4), .Q_RISE(qr4), .Q_FALL(qf4),
        .CPU_RESET_N(cr4), .READY(rd4)
    );

    cpu_phase_gen #(.DIV(1), .RST_HOLD(1)) dut1 (
        .CLK(clk), .RESET_N(reset_n), .LOCKED(locked), .STRETCH(stretch),
        .E(e1), .Q(q1), .E_RISE(er1), .E_FALL(ef1), .Q_RISE(qr1), .Q_FALL(qf1),
        .CPU_RESET_N(cr1), .READY(rd1)
    );

    int vectors = 0;
    int miscompares = 0;
    int cyc = 0;

    // Reference model: p counts non-stretched CLKs since HOLD entry; everything follows from it.
    int         m_div [2] = '{4, 1};
    int         m_hold[2] = '{2, 1};
    bit         m_s1  [2];
    bit         m_s2  [2];
    bit         m_run [2];
    int         m_p   [2];
    logic [7:0] m_exp [2];   // {E,Q,E_RISE,E_FALL,Q_RISE,Q_FALL,CPU_RESET_N,READY}

    int first_qr, first_er, first_qf, first_ef, first_rst4, first_rst1;

    function automatic void model_clear(int i);
        m_s1[i]  = 1'b0;
        m_s2[i]  = 1'b0;
        m_run[i] = 1'b0;
        m_p[i]   = 0;
        m_exp[i] = 8'h00;
    endfunction

    function automatic void model_edge(int i);
        bit lk, oe, oq, ne, nq, rel;
        int period, phase;
        if (!reset_n) begin
            model_clear(i);
            return;
        end
        lk      = m_s2[i];
        m_s2[i] = m_s1[i];
        m_s1[i] = locked;
        oe      = m_exp[i][7];
        oq      = m_exp[i][6];
        if (!m_run[i]) begin
            if (lk) begin
                m_run[i] = 1'b1;
                m_p[i]   = 0;
            end
            m_exp[i] = 8'h00;
        end else if (!lk) begin
            m_run[i] = 1'b0;
            m_exp[i] = 8'h00;
        end else begin
            period = 4 * m_div[i];
            if (!((m_p[i] % period) == period - 1 && stretch)) m_p[i]++;
            phase = (m_p[i] / m_div[i]) % 4;
            ne    = (phase >= 2);
            nq    = (phase == 1 || phase == 2);
            rel   = (m_p[i] >= m_hold[i] * period);
            m_exp[i] = {ne, nq, ne & ~oe, ~ne & oe, nq & ~oq, ~nq & oq, rel, rel};
        end
    endfunction

    task automatic check();
        logic [7:0] o4, o1;
        o4 = {e4, q4, er4, ef4, qr4, qf4, cr4, rd4};
        o1 = {e1, q1, er1, ef1, qr1, qf1, cr1, rd1};
        vectors++;
        assert (o4 === m_exp[0]) else begin
            miscompares++;
            $error("FAIL div4 cyc=%0d observed=%b expected=%b", cyc, o4, m_exp[0]);
        end
        vectors++;
        assert (o1 === m_exp[1]) else begin
            miscompares++;
            $error("FAIL div1 cyc=%0d observed=%b expected=%b", cyc, o1, m_exp[1]);
        end
        if (first_qr   < 0 && qr4) first_qr   = cyc;
        if (first_er   < 0 && er4) first_er   = cyc;
        if (first_qf   < 0 && qf4) first_qf   = cyc;
        if (first_ef   < 0 && ef4) first_ef   = cyc;
        if (first_rst4 < 0 && cr4) first_rst4 = cyc;
        if (first_rst1 < 0 && cr1) first_rst1 = cyc;
    endtask

    task automatic step();
        @(posedge clk);
        cyc++;
        model_edge(0);
        model_edge(1);
        #1;
        check();
    endtask

    task automatic reset_pulse(int cycles);
        reset_n = 1'b0;
        #1;
        model_clear(0);
        model_clear(1);
        check();
        for (int k = 0; k < cycles; k++) step();
        reset_n = 1'b1;
    endtask

    task automatic expect_int(string tag, int obs, int exp);
        vectors++;
        assert (obs == exp) else begin
            miscompares++;
            $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
        end
    endtask

    initial begin
        int rise_c, n, r;
        bit seen;
        first_qr = -1; first_er = -1; first_qf = -1;
        first_ef = -1; first_rst4 = -1; first_rst1 = -1;
        reset_n = 1'b1;
        locked  = 1'b0;
        stretch = 1'b0;
        #1;
        // Reset state, then first-lock timeline.
        reset_pulse(2);
        cyc = 0;
        while (cyc < 10) step();
        locked = 1'b1;
        while (cyc < 60) step();
        expect_int("q_rise_cyc", first_qr, 17);
        expect_int("e_rise_cyc", first_er, 21);
        expect_int("q_fall_cyc", first_qf, 25);
        expect_int("e_fall_cyc", first_ef, 29);
        expect_int("cpu_rst4_cyc", first_rst4, 45);
        expect_int("cpu_rst1_cyc", first_rst1, 17);

        // Stretch E high by 10 CLK.
        seen = 1'b0;
        for (int k = 0; k < 40 && !seen; k++) begin step(); seen = er4; end
        expect_int("wait_e_rise", int'(seen), 1);
        rise_c = cyc;
        for (int k = 0; k < 7; k++) step();
        stretch = 1'b1;
        for (int k = 0; k < 10; k++) step();
        stretch = 1'b0;
        seen = 1'b0;
        for (int k = 0; k < 40 && !seen; k++) begin step(); seen = ef4; end
        expect_int("e_fall_delay", cyc - rise_c, 18);

        // Lock loss while E is high.
        seen = 1'b0;
        for (int k = 0; k < 40 && !seen; k++) begin step(); seen = er4; end
        locked = 1'b0;
        for (int k = 0; k < 3; k++) step();
        expect_int("lock_drop_outs", int'({e4, q4, ef4, cr4, rd4}), 0);
        locked = 1'b1;
        for (int k = 0; k < 50; k++) step();

        // Async reset mid-HOLD after a re-lock.
        locked = 1'b0;
        for (int k = 0; k < 4; k++) step();
        locked = 1'b1;
        for (int k = 0; k < 12; k++) step();
        reset_pulse(2);
        for (int k = 0; k < 60; k++) step();

        // Random segments.
        for (int seg = 0; seg < 220; seg++) begin
            r = $urandom_range(0, 19);
            if (r < 12) begin
                n = $urandom_range(1, 30);
                for (int k = 0; k < n; k++) begin
                    stretch = ($urandom_range(0, 5) == 0);
                    step();
                end
                stretch = 1'b0;
            end else if (r < 16) begin
                stretch = 1'b1;
                n = $urandom_range(1, 25);
                for (int k = 0; k < n; k++) step();
                stretch = 1'b0;
            end else if (r < 18) begin
                locked = 1'b0;
                n = $urandom_range(1, 8);
                for (int k = 0; k < n; k++) step();
                locked = 1'b1;
            end else begin
                reset_pulse($urandom_range(1, 3));
            end
        end
        for (int k = 0; k < 20; k++) step();

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
